lin_accumulator: RTL and testbench

LIN_ACCUMULATOR -- requirements
Module: lin_accumulator

---
 rtl/main_pkg.sv | 16 +
 rtl/lns_term_shifter.sv | 39 +++
 rtl/lin_accumulator.sv | 101 ++++++++++
 tb/tb_lin_accumulator.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/main_pkg.sv
// Shared defaults and state types for the LNS datapath.
// Pipeline stages pick their default widths from here.
package main_pkg;

  localparam int Y_BITS   = 8;
  localparam int INT_BITS = 6;
  localparam int ACC_BITS = 32;
  localparam int ACC_FRAC = 16;
  localparam int CNT_BITS = 8;

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } acc_state_t;

endpackage

// File: rtl/lns_term_shifter.sv
// Turns an LNS mantissa/exponent/sign into a signed fixed-point term.
// Magnitudes beyond the positive accumulator range clamp to max.
module lns_term_shifter #(
  parameter int Y_BITS   = main_pkg::Y_BITS,
  parameter int INT_BITS = main_pkg::INT_BITS,
  parameter int ACC_BITS = main_pkg::ACC_BITS,
  parameter int ACC_FRAC = main_pkg::ACC_FRAC
) (
  input  logic [Y_BITS-1:0]   data_in,
  input  logic [INT_BITS-1:0] int_in,
  input  logic                sign_in,
  output logic [ACC_BITS-1:0] term
);

  // Wide enough that no left shift can lose bits before clamping.
  localparam int WW = ACC_FRAC + 1 + (1 << (INT_BITS - 1)) + ACC_BITS;
  localparam logic [ACC_BITS-1:0] MAXP = {1'b0, {(ACC_BITS-1){1'b1}}};

  logic [WW-1:0]       base;
  logic [WW-1:0]       mag;
  logic [INT_BITS-1:0] neg_amt;
  logic [ACC_BITS-1:0] clamp;

  always_comb begin
    base = {{(WW-Y_BITS-1){1'b0}}, 1'b1, data_in}
           << (ACC_FRAC - Y_BITS);
    neg_amt = -int_in;
    if (int_in[INT_BITS-1])
      mag = base >> neg_amt;
    else
      mag = base << int_in[INT_BITS-2:0];
    if (mag > {{(WW-ACC_BITS){1'b0}}, MAXP})
      clamp = MAXP;
    else
      clamp = mag[ACC_BITS-1:0];
    term = sign_in ? -clamp : clamp;
  end

endmodule

// File: rtl/lin_accumulator.sv
// Saturating dot-product accumulator for LNS-to-linear terms.
// One term per cycle; results held until consumed downstream.
module lin_accumulator #(
  parameter int Y_BITS   = main_pkg::Y_BITS,
  parameter int INT_BITS = main_pkg::INT_BITS,
  parameter int ACC_BITS = main_pkg::ACC_BITS,
  parameter int ACC_FRAC = main_pkg::ACC_FRAC,
  parameter int CNT_BITS = main_pkg::CNT_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                data_in_valid,
  output logic                data_in_enable,
  input  logic [Y_BITS-1:0]   data_in,
  input  logic [INT_BITS-1:0] int_in,
  input  logic                sign_in,
  input  logic                last_in,
  output logic                data_out_valid,
  input  logic                data_out_enable,
  output logic [ACC_BITS-1:0] data_out,
  output logic [CNT_BITS-1:0] count_out,
  output logic                ovf_out
);

  import main_pkg::*;

  localparam logic [ACC_BITS-1:0] MAXP = {1'b0, {(ACC_BITS-1){1'b1}}};
  localparam logic [ACC_BITS-1:0] MINN = {1'b1, {(ACC_BITS-1){1'b0}}};

  acc_state_t          state;
  logic [ACC_BITS-1:0] acc;
  logic [CNT_BITS-1:0] cnt;
  logic                flag;

  logic [ACC_BITS-1:0] term;
  logic [ACC_BITS:0]   sum_w;
  logic [ACC_BITS-1:0] sat;
  logic                add_ovf;
  logic [CNT_BITS-1:0] cnt_inc;
  logic                xfer_in;
  logic                xfer_out;

  lns_term_shifter #(
    .Y_BITS   (Y_BITS),
    .INT_BITS (INT_BITS),
    .ACC_BITS (ACC_BITS),
    .ACC_FRAC (ACC_FRAC)
  ) u_shift (
    .data_in (data_in),
    .int_in  (int_in),
    .sign_in (sign_in),
    .term    (term)
  );

  assign data_out_valid = (state == ST_OUT);
  assign data_in_enable = (state == ST_ACC) | data_out_enable;
  assign xfer_in        = data_in_valid & data_in_enable;
  assign xfer_out       = data_out_valid & data_out_enable;

  always_comb begin
    sum_w   = {acc[ACC_BITS-1], acc} + {term[ACC_BITS-1], term};
    add_ovf = sum_w[ACC_BITS] ^ sum_w[ACC_BITS-1];
    if (add_ovf)
      sat = sum_w[ACC_BITS] ? MINN : MAXP;
    else
      sat = sum_w[ACC_BITS-1:0];
    cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
  end

  // In OUT the accumulator is already clear, so a term accepted
  // alongside a transfer out starts the next product from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ACC;
      acc       <= '0;
      cnt       <= '0;
      flag      <= 1'b0;
      data_out  <= '0;
      count_out <= '0;
      ovf_out   <= 1'b0;
    end else if (xfer_in) begin
      if (last_in) begin
        data_out  <= sat;
        count_out <= cnt_inc;
        ovf_out   <= flag | add_ovf;
        acc       <= '0;
        cnt       <= '0;
        flag      <= 1'b0;
        state     <= ST_OUT;
      end else begin
        acc   <= sat;
        cnt   <= cnt_inc;
        flag  <= flag | add_ovf;
        state <= ST_ACC;
      end
    end else if (xfer_out) begin
      state <= ST_ACC;
    end
  end

endmodule

// File: tb/tb_lin_accumulator.sv
// Directed table-driven bench for lin_accumulator.
// Default widths: Y=8, INT=6, ACC=32 (16 frac), CNT=8.
module tb_lin_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_in_valid;
  logic        data_in_enable;
  logic [7:0]  data_in;
  logic [5:0]  int_in;
  logic        sign_in;
  logic        last_in;
  logic        data_out_valid;
  logic        data_out_enable;
  logic [31:0] data_out;
  logic [7:0]  count_out;
  logic        ovf_out;

  int checks = 0;
  int errors = 0;

  lin_accumulator dut (
    .clk             (clk),
    .rst             (rst),
    .data_in_valid   (data_in_valid),
    .data_in_enable  (data_in_enable),
    .data_in         (data_in),
    .int_in          (int_in),
    .sign_in         (sign_in),
    .last_in         (last_in),
    .data_out_valid  (data_out_valid),
    .data_out_enable (data_out_enable),
    .data_out        (data_out),
    .count_out       (count_out),
    .ovf_out         (ovf_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  f;
    int          e;
    logic        s;
    logic        last;
    logic [31:0] x_data;
    logic [7:0]  x_cnt;
    logic        x_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] f, input int e,
                       input logic s, input logic last);
    data_in_valid = 1'b1;
    data_in = f;
    int_in = 6'(e);
    sign_in = s;
    last_in = last;
  endtask

  task automatic idle();
    data_in_valid = 1'b0;
    last_in = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] f, input int e,
                     input logic s, input logic last);
    drive(f, e, s, last);
    step();
    idle();
  endtask

  task automatic consume();
    data_out_enable = 1'b1;
    step();
    data_out_enable = 1'b0;
  endtask

  task automatic chk_res(input string name, input logic [31:0] d,
                         input logic [7:0] c, input logic o);
    chk({name, ".valid"}, 64'(data_out_valid), 64'd1);
    chk({name, ".data"}, 64'(data_out), 64'(d));
    chk({name, ".count"}, 64'(count_out), 64'(c));
    chk({name, ".ovf"}, 64'(ovf_out), 64'(o));
  endtask

  initial begin
    vecs.push_back('{8'h80,   2, 0, 0, 32'h0, 8'd0, 0});
    vecs.push_back('{8'h00,  -1, 1, 1, 32'h00058000, 8'd2, 0});
    vecs.push_back('{8'h00,  14, 0, 0, 32'h0, 8'd0, 0});
    vecs.push_back('{8'h00,  14, 0, 1, 32'h7FFFFFFF, 8'd2, 1});
    vecs.push_back('{8'h00,   0, 0, 1, 32'h00010000, 8'd1, 0});
    vecs.push_back('{8'hFF, -17, 0, 1, 32'h0, 8'd1, 0});
    vecs.push_back('{8'h00,  14, 1, 0, 32'h0, 8'd0, 0});
    vecs.push_back('{8'h00,  14, 1, 0, 32'h0, 8'd0, 0});
    vecs.push_back('{8'h00,   0, 1, 1, 32'h80000000, 8'd3, 1});
    vecs.push_back('{8'h00,  31, 0, 1, 32'h7FFFFFFF, 8'd1, 0});
    vecs.push_back('{8'h00, -32, 0, 1, 32'h0, 8'd1, 0});
    vecs.push_back('{8'h00, -16, 0, 0, 32'h0, 8'd0, 0});
    vecs.push_back('{8'h01,  -8, 1, 1, 32'hFFFFFF00, 8'd2, 0});

    rst = 1'b1;
    data_out_enable = 1'b0;
    data_in = '0;
    int_in = '0;
    sign_in = 1'b0;
    idle();
    step();
    step();
    chk("rst.valid", 64'(data_out_valid), 64'd0);
    chk("rst.data", 64'(data_out), 64'd0);
    chk("rst.count", 64'(count_out), 64'd0);
    chk("rst.ovf", 64'(ovf_out), 64'd0);
    rst = 1'b0;
    step();
    chk("rst.in_en", 64'(data_in_enable), 64'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      put(vecs[i].f, vecs[i].e, vecs[i].s, vecs[i].last);
      if (vecs[i].last) begin
        chk_res($sformatf("vec%0d", i), vecs[i].x_data,
                vecs[i].x_cnt, vecs[i].x_ovf);
        consume();
        chk($sformatf("vec%0d.drain", i), 64'(data_out_valid), 64'd0);
      end else begin
        chk($sformatf("vec%0d.busy", i), 64'(data_out_valid), 64'd0);
      end
    end

    // Stall: result pending, new last term waiting upstream
    put(8'h00, 0, 0, 1);
    chk_res("stall.pre", 32'h00010000, 8'd1, 1'b0);
    drive(8'h00, 1, 0, 1);
    for (int k = 0; k < 3; k++) begin
      chk("stall.in_en", 64'(data_in_enable), 64'd0);
      step();
      chk_res("stall.hold", 32'h00010000, 8'd1, 1'b0);
    end
    data_out_enable = 1'b1;
    #1;
    chk("stall.pass", 64'(data_in_enable), 64'd1);
    step();
    data_out_enable = 1'b0;
    idle();
    chk_res("stall.next", 32'h00020000, 8'd1, 1'b0);
    consume();

    // Transfer out with a non-last term starts a new product
    put(8'h00, 0, 0, 1);
    drive(8'h00, 0, 0, 0);
    data_out_enable = 1'b1;
    step();
    data_out_enable = 1'b0;
    idle();
    chk("swap.valid", 64'(data_out_valid), 64'd0);
    put(8'h00, 0, 0, 1);
    chk_res("swap.res", 32'h00020000, 8'd2, 1'b0);
    consume();

    // Reset mid-accumulation drops the partial sum
    for (int k = 0; k < 3; k++) put(8'h00, 3, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst.valid", 64'(data_out_valid), 64'd0);
    chk("mrst.in_en", 64'(data_in_enable), 64'd1);
    step();
    chk("mrst.valid2", 64'(data_out_valid), 64'd0);
    put(8'h00, 0, 0, 0);
    put(8'h00, 0, 0, 1);
    chk_res("mrst.res", 32'h00020000, 8'd2, 1'b0);
    consume();

    // Counter saturation with zero-magnitude terms
    for (int k = 0; k < 300; k++) put(8'h00, -32, 0, 0);
    put(8'h00, 0, 0, 1);
    chk_res("csat", 32'h00010000, 8'd255, 1'b0);
    consume();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
